// File: rtl/serializer.sv
// serializer: MSB-first parallel-to-serial transmitter with per-bit valid strobe.
// Define SERIALIZER_BACK2BACK_EN to drop busy_o during the last bit so words stream gap-free.
module serializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);
  localparam int CNT_W = MOD_W + 1;
`ifdef SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  len;
  logic              ser_q;
  logic              val_q;
  logic              busy_q;
  logic              accept;
  always_comb begin
    len    = (data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, data_mod_i};
    accept = data_val_i && !busy_q && len >= CNT_W'(MIN_LEN);
  end
  // cnt_q counts bits still to go, including the one currently on ser_data_o
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      state_q <= SEND;
      sreg_q  <= data_i << 1;
      cnt_q   <= len;
      ser_q   <= data_i[DATA_W-1];
      val_q   <= 1'b1;
      busy_q  <= !B2B || len != CNT_W'(1);
    end else if (state_q == SEND && cnt_q != CNT_W'(1)) begin
      sreg_q  <= sreg_q << 1;
      cnt_q   <= cnt_q - 1'b1;
      ser_q   <= sreg_q[DATA_W-1];
      busy_q  <= !B2B || cnt_q != CNT_W'(2);
    end else begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end
  end
  assign ser_data_o     = ser_q;
  assign ser_data_val_o = val_q;
  assign busy_o         = busy_q;
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed checks of the serializer against hand-computed bit streams.
module tb_serializer;
`ifdef SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o, ser_data_val_o, busy_o;
  int          errors = 0;
  int          checks = 0;

  serializer dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ser_data_o(ser_data_o), .ser_data_val_o(ser_data_val_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".val"}, ser_data_val_o, 1'b0);
    chk({tag, ".dat"}, ser_data_o, 1'b0);
    chk({tag, ".busy"}, busy_o, 1'b0);
  endtask

  task automatic send_word(input string tag, input logic [15:0] d, input logic [3:0] m);
    int len;
    len = (m == 0) ? 16 : int'(m);
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s.val[%0d]", tag, i), ser_data_val_o, 1'b1);
      chk($sformatf("%s.bit[%0d]", tag, i), ser_data_o, d[15-i]);
      chk($sformatf("%s.busy[%0d]", tag, i), busy_o, B2B ? (i < len - 1) : 1'b1);
      tick();
    end
    chk_idle({tag, ".end"});
  endtask

  task automatic reject(input string tag, input logic [15:0] d, input logic [3:0] m);
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
    chk_idle({tag, ".c1"});
    tick();
    chk_idle({tag, ".c2"});
  endtask

  initial begin
    logic [10:0] ev, ed, eb;
    #1;
    chk_idle("reset");
    tick();
    arst_n_i = 1'b1;
    tick();
    chk_idle("post_reset");

    send_word("full", 16'hA5C3, 4'd0);
    tick();
    send_word("short3", 16'hE000, 4'd3);
    reject("mod1", 16'hE000, 4'd1);
    reject("mod2", 16'hE000, 4'd2);
    send_word("short5", 16'h4FFF, 4'd5);

    data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drop.val[%0d]", i), ser_data_val_o, 1'b1);
      chk($sformatf("drop.bit[%0d]", i), ser_data_o, 1'b1);
      data_i = 16'h0000;
      data_val_i = (i == 4);
      tick();
      data_val_i = 1'b0;
    end
    chk_idle("drop.end");
    tick();
    chk_idle("drop.end2");

    ev = B2B ? 11'b11111111000 : 11'b11110111100;
    ed = 11'b11110000000;
    eb = B2B ? 11'b11101110000 : 11'b11110111100;
    data_i = 16'hF000; data_mod_i = 4'd4; data_val_i = 1'b1;
    tick();
    data_i = 16'h0000;
    for (int c = 0; c < 11; c++) begin
      if (c == (B2B ? 4 : 5)) data_val_i = 1'b0;
      chk($sformatf("b2b.val[%0d]", c), ser_data_val_o, ev[10-c]);
      chk($sformatf("b2b.dat[%0d]", c), ser_data_o, ed[10-c]);
      chk($sformatf("b2b.busy[%0d]", c), busy_o, eb[10-c]);
      tick();
    end

    data_i = 16'hAAAA; data_mod_i = 4'd0; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst.pre_val", ser_data_val_o, 1'b1);
    chk("rst.pre_bit", ser_data_o, 1'b1);
    arst_n_i = 1'b0;
    #1;
    chk_idle("rst.async");
    tick();
    chk_idle("rst.held");
    arst_n_i = 1'b1;
    tick();
    chk_idle("rst.released");
    send_word("after_rst", 16'h8000, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
